usb_sie_tx: RTL and testbench

//  SIE transmit packetizer sitting directly upstream of the UTM transmit side. Takes packet requests
//  (handshake or DATA) from the endpoint/protocol layer plus a byte stream, forms PID byte, payload
//  and CRC16, and drives the UTMI byte handshake (tx_valid/tx_ready). Flags underrun/overlength.

---
 rtl/usb_sie_tx.sv | 90 +++++++++
 tb/tb_usb_sie_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/usb_sie_tx.sv
// usb_sie_tx: SIE transmit packetizer forming PID, payload and CRC16 onto the UTMI byte handshake
module usb_sie_tx #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_start,
  input  logic [3:0] pkt_pid,
  input  logic       pkt_data,
  input  logic       pkt_zlp,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  input  logic       pl_last,
  output logic       pl_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] data_out,
  output logic       tx_valid,
  input  logic       tx_ready
);
  localparam int CW = $clog2(MAX_PAYLOAD + 2);
  localparam logic [2:0] S_IDLE = 3'd0, S_PID = 3'd1, S_DATA = 3'd2, S_CRC_LO = 3'd3, S_CRC_HI = 3'd4;
  logic [2:0] state;
  logic [3:0] pid;
  logic is_data, zlp;
  logic [15:0] crc, crc_nxt;
  logic [CW-1:0] cnt;
  logic accept;
  assign tx_valid = state != S_IDLE;
  assign busy = tx_valid;
  assign accept = tx_valid & tx_ready;
  assign pl_ready = (state == S_DATA) & pl_valid & accept;
  assign data_out = state == S_PID    ? {~pid, pid} :
                    state == S_DATA   ? pl_data :
                    state == S_CRC_LO ? ~crc[7:0] :
                    state == S_CRC_HI ? ~crc[15:8] : 8'h00;
  // reflected CRC16 (0xA001), one payload byte per accept, LSB first
  always_comb begin
    crc_nxt = crc;
    for (int i = 0; i < 8; i++)
      crc_nxt = (crc_nxt[0] ^ pl_data[i]) ? ((crc_nxt >> 1) ^ 16'hA001) : (crc_nxt >> 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pid     <= 4'h0;
      is_data <= 1'b0;
      zlp     <= 1'b0;
      crc     <= 16'hFFFF;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: if (pkt_start) begin
          pid     <= pkt_pid;
          is_data <= pkt_data;
          zlp     <= pkt_zlp;
          crc     <= 16'hFFFF;
          cnt     <= '0;
          state   <= S_PID;
        end
        S_PID: if (tx_ready) begin
          state <= !is_data ? S_IDLE : zlp ? S_CRC_LO : S_DATA;
          done  <= !is_data;
        end
        S_DATA: if (tx_ready) begin
          // a ready slot with no byte is an underrun; a byte past the limit is dropped
          if (!pl_valid || cnt == CW'(MAX_PAYLOAD)) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            crc <= crc_nxt;
            cnt <= cnt + 1'b1;
            if (pl_last) state <= S_CRC_LO;
          end
        end
        S_CRC_LO: if (tx_ready) state <= S_CRC_HI;
        S_CRC_HI: if (tx_ready) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_sie_tx.sv
// tb_usb_sie_tx: directed packets checked against a byte-queue model of the expected wire stream
module tb_usb_sie_tx;
  localparam int MAXP = 64;
  typedef struct {logic [7:0] b; bit pl;} ent_t;
  logic clk = 0, rst = 1;
  logic pkt_start = 0, pkt_data = 0, pkt_zlp = 0;
  logic [3:0] pkt_pid = 0;
  logic [7:0] pl_data = 0;
  logic pl_valid = 0, pl_last = 0, tx_ready = 0;
  logic pl_ready, busy, done, err, tx_valid;
  logic [7:0] data_out;
  int checks = 0, errors = 0;
  ent_t exp_q[$];
  ent_t e;
  logic [7:0] sent[$];
  logic [7:0] cbuf[0:127];
  int end_kind = 0, pend = 0, evt_cnt = 0;
  bit mon_en = 0, active = 0, hold = 0;
  logic [7:0] hold_val = 0;

  usb_sie_tx #(.MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .rst(rst), .pkt_start(pkt_start), .pkt_pid(pkt_pid), .pkt_data(pkt_data),
    .pkt_zlp(pkt_zlp), .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
    .pl_ready(pl_ready), .busy(busy), .done(done), .err(err), .data_out(data_out),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // normal (MSB-first, 0x8005) CRC on bit-reversed input, result reversed back into USB bit order
  function automatic logic [15:0] crc_of(input int len);
    logic [15:0] r, o;
    logic fb;
    r = 16'hFFFF;
    for (int k = 0; k < len; k++)
      for (int j = 0; j < 8; j++) begin
        fb = r[15] ^ cbuf[k][j];
        r = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    for (int j = 0; j < 16; j++) o[j] = r[15-j];
    return o;
  endfunction

  always @(negedge clk) if (mon_en) begin
    if (pend != 0) begin
      chk("end_done", {31'd0, done}, {31'd0, pend == 1});
      chk("end_err", {31'd0, err}, {31'd0, pend == 2});
      chk("end_busy", {31'd0, busy}, 0);
      chk("end_txv", {31'd0, tx_valid}, 0);
      pend = 0;
      active = 0;
      evt_cnt++;
    end else chk("no_pulse", {30'd0, done, err}, 0);
    if (tx_valid) active = 1;
    if (active && exp_q.size() > 0) begin
      chk("txv_cont", {31'd0, tx_valid}, 1);
      chk("busy_cont", {31'd0, busy}, 1);
    end
    if (hold && tx_valid) chk("hold_stable", {24'd0, data_out}, {24'd0, hold_val});
    hold = tx_valid && !tx_ready;
    hold_val = data_out;
    if (tx_valid && tx_ready) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("byte", {24'd0, data_out}, {24'd0, e.b});
        chk("pl_ready", {31'd0, pl_ready}, {31'd0, e.pl});
        sent.push_back(data_out);
        if (exp_q.size() == 0 && end_kind == 0) pend = 1;
      end else if (end_kind == 1 && active) pend = 2;
      else begin
        checks++;
        errors++;
        $display("FAIL unexpected_accept: byte %0h with nothing expected", data_out);
      end
    end else chk("pl_ready_idle", {31'd0, pl_ready}, 0);
  end

  // und: payload index where pl_valid drops (-1 = never); last=0 streams without pl_last
  task automatic run_pkt(input logic [3:0] pid, input bit data, input bit zlp, input int n,
                         input bit last, input int und, input bit tog);
    int lim, i, k, e0;
    bit adv;
    logic [15:0] c;
    sent.delete();
    exp_q.push_back('{{~pid, pid}, 1'b0});
    lim = n;
    if (und >= 0 && und < lim) lim = und;
    if (!last && lim > MAXP) lim = MAXP;
    end_kind = (data && !zlp && (und >= 0 || !last)) ? 1 : 0;
    if (data && !zlp) for (int j = 0; j < lim; j++) exp_q.push_back('{8'(j), 1'b1});
    if (data && end_kind == 0) begin
      for (int j = 0; j < n; j++) cbuf[j] = 8'(j);
      c = ~crc_of(zlp ? 0 : n);
      exp_q.push_back('{c[7:0], 1'b0});
      exp_q.push_back('{c[15:8], 1'b0});
    end
    e0 = evt_cnt;
    @(posedge clk); #1;
    pkt_start = 1; pkt_pid = pid; pkt_data = data; pkt_zlp = zlp;
    @(posedge clk); #1;
    pkt_start = 0;
    chk("latency_txv", {31'd0, tx_valid}, 1);
    chk("pid_byte", {24'd0, data_out}, {24'd0, ~pid, pid});
    i = 0;
    k = 0;
    while (evt_cnt == e0 && k < 400) begin
      tx_ready = tog ? (k % 2 == 0) : 1'b1;
      pl_valid = data && !zlp && i < n && i != und;
      pl_data = i < n ? 8'(i) : 8'h00;
      pl_last = last && i == n - 1;
      @(negedge clk);
      adv = pl_ready;
      @(posedge clk); #1;
      if (adv) i++;
      k++;
    end
    if (evt_cnt == e0) begin
      checks++;
      errors++;
      $display("FAIL timeout: packet pid %0h never ended", pid);
    end
    tx_ready = 0; pl_valid = 0; pl_last = 0;
  endtask

  initial begin
    logic [15:0] r;
    logic [7:0] s0;
    @(posedge clk); #1;
    chk("rst_txv", {31'd0, tx_valid}, 0);
    chk("rst_data", {24'd0, data_out}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_plr", {31'd0, pl_ready}, 0);
    @(posedge clk); #1;
    rst = 0;
    for (int j = 0; j < 9; j++) cbuf[j] = 8'h31 + 8'(j);
    r = ~crc_of(9);
    chk("model_check_123456789", {16'd0, r}, 32'hB4C8);
    mon_en = 1;
    run_pkt(4'h2, 0, 0, 0, 1, -1, 0);
    s0 = sent.size() > 0 ? sent[0] : 8'hxx;
    chk("ack_lit", {24'd0, s0}, 32'hD2);
    chk("ack_len", sent.size(), 1);
    run_pkt(4'hB, 1, 1, 0, 1, -1, 0);
    chk("zlp_len", sent.size(), 3);
    if (sent.size() == 3) begin
      chk("zlp_b0", {24'd0, sent[0]}, 32'h4B);
      chk("zlp_b1", {24'd0, sent[1]}, 32'h00);
      chk("zlp_b2", {24'd0, sent[2]}, 32'h00);
    end
    run_pkt(4'h3, 1, 0, 4, 1, -1, 1);
    chk("d0_len", sent.size(), 7);
    chk("d0_pid", {24'd0, sent[0]}, 32'hC3);
    for (int j = 1; j < sent.size(); j++) cbuf[j-1] = sent[j];
    chk("d0_residual", {16'd0, crc_of(sent.size() - 1)}, 32'hB001);
    run_pkt(4'hB, 1, 0, 5, 1, 2, 0);
    chk("und_len", sent.size(), 3);
    run_pkt(4'h3, 1, 0, MAXP + 1, 0, -1, 0);
    chk("ovl_len", sent.size(), MAXP + 1);
    mon_en = 0;
    exp_q.delete();
    @(posedge clk); #1;
    pkt_start = 1; pkt_pid = 4'h3; pkt_data = 1; pkt_zlp = 0;
    tx_ready = 1; pl_valid = 1; pl_data = 8'h55;
    @(posedge clk); #1;
    pkt_start = 0;
    @(posedge clk); @(posedge clk); #2;
    chk("pre_rst_busy", {31'd0, busy}, 1);
    rst = 1;
    #1;
    chk("mid_rst_txv", {31'd0, tx_valid}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_data", {24'd0, data_out}, 0);
    @(posedge clk); #1;
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_err", {31'd0, err}, 0);
    rst = 0; tx_ready = 0; pl_valid = 0;
    active = 0; pend = 0; hold = 0;
    mon_en = 1;
    run_pkt(4'h2, 0, 0, 0, 1, -1, 0);
    s0 = sent.size() > 0 ? sent[0] : 8'hxx;
    chk("ack2_lit", {24'd0, s0}, 32'hD2);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
